enemy_formation: RTL
====================

// Module: enemy_formation
// PURPOSE
//  Owns the full invader grid: alive mask, marching motion (step, edge-drop, reverse), player-shot collision,
//  score accumulation, pixel rendering. Replaces per-enemy instances + top-level position regs with one
//  parametrised block; feeds the VGA OR-mixer (R/G/B) and the game engine (alive, score, wave_clear, invaded).
// PARAMETERS
//  N_COLS     8        enemies per row (1..16)
//  N_ROWS     3        rows (1..4)
//  X0 / Y0    180/40   formation origin (top-left of enemy 0) after reset/restart
//  DX / DY    80/50    column / row pitch, px
//  SPR_W/H    32/24    enemy bounding box, px
//  X_MAX      799      rightmost legal pixel column; leftmost is 0
//  STEP_PX    4        horizontal move per tick
//  DROP_PX    16       vertical move on edge hit
//  TICK_DIV   1000000  clk cycles per movement tick
//  INVADE_Y   400      bottom of lowest alive row >= INVADE_Y -> invaded
//  PTS_ROW0   30       points for row 0; row r pays PTS_ROW0 - 10*r, floor 10
// PORTS
//  clk          in   1        system clock
//  reset        in   1        asynchronous, active-low
//  restart      in   1        sync pulse: new wave (alive all 1, origin X0/Y0, direction right); score kept
//  h_counter    in   10       current VGA pixel x
//  v_counter    in   10       current VGA pixel y
//  shot_active  in   1        player shot in flight
//  shot_x       in   11       player shot x
//  shot_y       in   11       player shot y
//  alive        out  N_ROWS*N_COLS  bit r*N_COLS+c = enemy (r,c) alive
//  hit          out  1        1-cycle pulse on a kill
//  hit_id       out  8        index of killed enemy, valid with hit
//  score        out  32       accumulated points
//  wave_clear   out  1        level: alive == 0
//  invaded      out  1        level: formation reached INVADE_Y
//  R/G/B        out  8 each   enemy pixel colour, 0 when no enemy at (h,v)
//  fire_req, fire_x[10:0], fire_y[10:0], fire_ack(in)   present only with ENEMY_FIRE_EN
// BEHAVIOUR
//  Reset: alive all 1, base_x=X0, base_y=Y0, dir=right, state MARCH, score=0, hit=0, hit_id=0,
//   wave_clear=0, invaded=0, R/G/B=0, tick counter=0, fire_req=0. Reset mid-wave aborts everything immediately.
//  FSM: MARCH -> DROP (edge) -> MARCH; MARCH/DROP -> CLEARED (alive==0); MARCH/DROP -> INVADED;
//   CLEARED/INVADED -> MARCH only on restart. No motion in CLEARED/INVADED.
//  Tick: counter 0..TICK_DIV-1, tick on wrap. In MARCH on tick: compute edge from min/max alive column;
//   right: if base_x+maxc*DX+SPR_W-1+STEP_PX > X_MAX -> DROP else base_x += STEP_PX;
//   left:  if base_x+minc*DX < STEP_PX -> DROP else base_x -= STEP_PX.
//   DROP (next tick): base_y += DROP_PX, dir flips, back to MARCH. Exactly one drop per edge contact.
//  Collision (every cycle, shot_active=1): shot point inside [x,x+SPR_W)x[y,y+SPR_H) of an alive enemy ->
//   clear its alive bit next cycle, hit=1 for 1 cycle, hit_id=index, score += row points. Multiple overlaps:
//   lowest index wins, one kill per cycle. Hit and tick same cycle: hit tested on pre-move position, both apply.
//  Dead enemies never render nor collide. Edges recomputed from current alive mask (formation widens reach).
//  restart has priority over tick and hit in the same cycle; a hit that cycle is discarded.
//  Render: R/G/B registered, 1-cycle latency from h/v_counter; alive enemy pixel = row colour
//   (row0 FF/00/FF, row1 00/FF/FF, else 00/FF/00). Arithmetic 11-bit unsigned, no wrap (edge rules prevent it).
// CONFIGURATION
//  ENEMY_FIRE_EN defined: 16-bit LFSR (seed 16'hACE1) picks a column on each tick; lowest alive enemy of that
//   column drives fire_x=centre x, fire_y=bottom y, fire_req=1 held until fire_ack; empty column -> no request.
//  Undefined: fire ports absent, LFSR not built; all other behaviour identical.
// STRUCTURE
//  invaders_pkg: screen limits, SPR_W/H, row colour constants, enemy index width.
//  Sub-module enemy_hit_detect: combinational N_ROWS*N_COLS box test + priority encoder -> hit/hit_id.
//  Top holds FSM, tick divider, alive/score regs, render, optional LFSR.
// TESTING
//  reset low then high -> alive=24'hFFFFFF, base (180,40), score 0, R/G/B 0; reset low mid-march -> same.
//  TICK_DIV=4, no shots -> base_x 184..208 over 7 ticks, tick 8 DROP, tick 9 base_y=56 dir=left.
//  shot (185,45) active -> hit pulse 1 cycle, hit_id 0, alive[0]=0, score 30; repeat same point -> no hit.
//  kill column 7 (ids 7,15,23) -> right edge uses col 6; drop occurs at base_x 288 instead of 208.
//  kill all 24 -> wave_clear=1, CLEARED, score 480, base frozen; restart -> alive all 1, score 480 kept.
//  ENEMY_FIRE_EN, column 2 rows 0-1 dead -> fire_x=356, fire_y=163; fire_req holds until fire_ack.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared constants for the invader formation: screen limits, sprite box, row colours,
// index widths, FSM/direction encodings and the per-row scoring rule.
package invaders_pkg;
    localparam int unsigned SCREEN_X_MAX = 799;
    localparam int unsigned ENEMY_W      = 32;
    localparam int unsigned ENEMY_H      = 24;
    localparam int unsigned IDX_W        = 8;
    localparam int unsigned COL_W        = 4;
    localparam int unsigned ROW_W        = 2;

    localparam logic [23:0] RGB_ROW0 = 24'hFF00FF;
    localparam logic [23:0] RGB_ROW1 = 24'h00FFFF;
    localparam logic [23:0] RGB_ROWN = 24'h00FF00;

    typedef enum logic [1:0] {ST_MARCH, ST_DROP, ST_CLEARED, ST_INVADED} fm_state_t;
    typedef enum logic {DIR_RIGHT, DIR_LEFT} fm_dir_t;

    // Row r pays pts0 - 10*r, never less than 10.
    function automatic logic [31:0] row_points(input logic [31:0] pts0, input logic [31:0] row);
        logic [31:0] cut;
        cut = row * 32'd10;
        return (cut + 32'd10 >= pts0) ? 32'd10 : pts0 - cut;
    endfunction
endpackage

// File: rtl/enemy_formation_if.sv
// Player-shot / kill-report bus between the game engine and the formation
// (plus the enemy fire request handshake when ENEMY_FIRE_EN is defined).
interface enemy_formation_if;
    logic        shot_active;
    logic [10:0] shot_x;
    logic [10:0] shot_y;
    logic        hit;
    logic [7:0]  hit_id;
`ifdef ENEMY_FIRE_EN
    logic        fire_req;
    logic [10:0] fire_x;
    logic [10:0] fire_y;
    logic        fire_ack;
`endif

    modport master (
        output shot_active, shot_x, shot_y,
        input  hit, hit_id
`ifdef ENEMY_FIRE_EN
        , input fire_req, fire_x, fire_y, output fire_ack
`endif
    );

    modport slave (
        input  shot_active, shot_x, shot_y,
        output hit, hit_id
`ifdef ENEMY_FIRE_EN
        , output fire_req, fire_x, fire_y, input fire_ack
`endif
    );
endinterface

// File: rtl/enemy_hit_detect.sv
// Combinational box test of one point against every alive enemy; lowest index wins.
module enemy_hit_detect
    import invaders_pkg::*;
#(
    parameter int unsigned N_COLS = 8,
    parameter int unsigned N_ROWS = 3,
    parameter int unsigned DX     = 80,
    parameter int unsigned DY     = 50,
    parameter int unsigned SPR_W  = ENEMY_W,
    parameter int unsigned SPR_H  = ENEMY_H
) (
    input  logic [N_ROWS*N_COLS-1:0] alive,
    input  logic [10:0]              base_x,
    input  logic [10:0]              base_y,
    input  logic                     active,
    input  logic [10:0]              pt_x,
    input  logic [10:0]              pt_y,
    output logic                     hit,
    output logic [IDX_W-1:0]         hit_id,
    output logic [ROW_W-1:0]         hit_row
);
    logic [11:0] ex, ey;

    always_comb begin
        hit     = 1'b0;
        hit_id  = '0;
        hit_row = '0;
        ex      = '0;
        ey      = '0;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            for (int unsigned c = 0; c < N_COLS; c++) begin
                ex = 12'(base_x) + 12'(c * DX);
                ey = 12'(base_y) + 12'(r * DY);
                if (active && !hit && alive[r*N_COLS + c] &&
                    12'(pt_x) >= ex && 12'(pt_x) < ex + 12'(SPR_W) &&
                    12'(pt_y) >= ey && 12'(pt_y) < ey + 12'(SPR_H)) begin
                    hit     = 1'b1;
                    hit_id  = IDX_W'(r * N_COLS + c);
                    hit_row = ROW_W'(r);
                end
            end
        end
    end
endmodule

// File: rtl/enemy_formation.sv
// Invader grid: alive mask, marching motion, shot collision, score and pixel render.
// Optional enemy fire (LFSR column pick + req/ack) is built when ENEMY_FIRE_EN is defined.
module enemy_formation
    import invaders_pkg::*;
#(
    parameter int unsigned N_COLS   = 8,
    parameter int unsigned N_ROWS   = 3,
    parameter int unsigned X0       = 180,
    parameter int unsigned Y0       = 40,
    parameter int unsigned DX       = 80,
    parameter int unsigned DY       = 50,
    parameter int unsigned SPR_W    = ENEMY_W,
    parameter int unsigned SPR_H    = ENEMY_H,
    parameter int unsigned X_MAX    = SCREEN_X_MAX,
    parameter int unsigned STEP_PX  = 4,
    parameter int unsigned DROP_PX  = 16,
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned INVADE_Y = 400,
    parameter int unsigned PTS_ROW0 = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     restart,
    input  logic [9:0]               h_counter,
    input  logic [9:0]               v_counter,
    enemy_formation_if.slave         shot_if,
    output logic [N_ROWS*N_COLS-1:0] alive,
    output logic [31:0]              score,
    output logic                     wave_clear,
    output logic                     invaded,
    output logic [7:0]               R,
    output logic [7:0]               G,
    output logic [7:0]               B
);
    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    fm_state_t          state, state_nxt;
    fm_dir_t            dir;
    logic [10:0]        base_x, base_y;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic [N_COLS-1:0]  col_any;
    logic [N_ROWS-1:0]  row_any;
    logic [COL_W-1:0]   minc, maxc;
    logic [ROW_W-1:0]   maxr;
    logic [11:0]        right_reach, left_pos, bottom;
    logic               edge_hit, reached, moving;
    logic               hit_now;
    logic [IDX_W-1:0]   hit_id_now;
    logic [ROW_W-1:0]   hit_row_now;
    logic               pix_on;
    logic [ROW_W-1:0]   pix_row;
    logic [11:0]        px_ex, px_ey;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 1'b1;
    end

    // Occupied columns/rows of the current mask set the reach of the formation.
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int unsigned r = 0; r < N_ROWS; r++)
            for (int unsigned c = 0; c < N_COLS; c++)
                if (alive[r*N_COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
        minc = '0;
        maxc = '0;
        maxr = '0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            if (col_any[c]) maxc = COL_W'(c);
            if (col_any[N_COLS-1-c]) minc = COL_W'(N_COLS - 1 - c);
        end
        for (int unsigned r = 0; r < N_ROWS; r++)
            if (row_any[r]) maxr = ROW_W'(r);
    end

    assign right_reach = 12'(base_x) + 12'(maxc) * 12'(DX) + 12'(SPR_W - 1 + STEP_PX);
    assign left_pos    = 12'(base_x) + 12'(minc) * 12'(DX);
    assign bottom      = 12'(base_y) + 12'(maxr) * 12'(DY) + 12'(SPR_H - 1);
    assign edge_hit    = (dir == DIR_RIGHT) ? (right_reach > 12'(X_MAX)) : (left_pos < 12'(STEP_PX));
    assign reached     = (|alive) && (bottom >= 12'(INVADE_Y));
    assign moving      = tick && (|alive) && !reached;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_MARCH;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_MARCH;
        end else if (state == ST_MARCH || state == ST_DROP) begin
            if (~|alive) state_nxt = ST_CLEARED;
            else if (reached) state_nxt = ST_INVADED;
            else if (tick && state == ST_DROP) state_nxt = ST_MARCH;
            else if (tick && edge_hit) state_nxt = ST_DROP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_x <= 11'(X0);
            base_y <= 11'(Y0);
            dir    <= DIR_RIGHT;
        end else if (restart) begin
            base_x <= 11'(X0);
            base_y <= 11'(Y0);
            dir    <= DIR_RIGHT;
        end else if (moving && state == ST_DROP) begin
            base_y <= base_y + 11'(DROP_PX);
            dir    <= (dir == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        end else if (moving && state == ST_MARCH && !edge_hit) begin
            if (dir == DIR_RIGHT) base_x <= base_x + 11'(STEP_PX);
            else base_x <= base_x - 11'(STEP_PX);
        end
    end

    enemy_hit_detect #(
        .N_COLS(N_COLS), .N_ROWS(N_ROWS), .DX(DX), .DY(DY), .SPR_W(SPR_W), .SPR_H(SPR_H)
    ) u_hit (
        .alive  (alive),
        .base_x (base_x),
        .base_y (base_y),
        .active (shot_if.shot_active),
        .pt_x   (shot_if.shot_x),
        .pt_y   (shot_if.shot_y),
        .hit    (hit_now),
        .hit_id (hit_id_now),
        .hit_row(hit_row_now)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive          <= '1;
            score          <= '0;
            shot_if.hit    <= 1'b0;
            shot_if.hit_id <= '0;
        end else begin
            shot_if.hit <= 1'b0;
            if (restart) begin
                alive <= '1;
            end else if (hit_now) begin
                alive          <= alive & ~((N_ROWS*N_COLS)'(1) << hit_id_now);
                score          <= score + row_points(32'(PTS_ROW0), 32'(hit_row_now));
                shot_if.hit    <= 1'b1;
                shot_if.hit_id <= hit_id_now;
            end
        end
    end

    assign wave_clear = ~|alive;
    assign invaded    = (state == ST_INVADED);

    always_comb begin
        pix_on  = 1'b0;
        pix_row = '0;
        px_ex   = '0;
        px_ey   = '0;
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            for (int unsigned c = 0; c < N_COLS; c++) begin
                px_ex = 12'(base_x) + 12'(c * DX);
                px_ey = 12'(base_y) + 12'(r * DY);
                if (!pix_on && alive[r*N_COLS + c] &&
                    12'(h_counter) >= px_ex && 12'(h_counter) < px_ex + 12'(SPR_W) &&
                    12'(v_counter) >= px_ey && 12'(v_counter) < px_ey + 12'(SPR_H)) begin
                    pix_on  = 1'b1;
                    pix_row = ROW_W'(r);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) {R, G, B} <= '0;
        else if (!pix_on) {R, G, B} <= '0;
        else if (pix_row == ROW_W'(0)) {R, G, B} <= RGB_ROW0;
        else if (pix_row == ROW_W'(1)) {R, G, B} <= RGB_ROW1;
        else {R, G, B} <= RGB_ROWN;
    end

`ifdef ENEMY_FIRE_EN
    logic [15:0]      lfsr;
    logic [COL_W-1:0] fire_col;
    logic [ROW_W-1:0] fire_row;
    logic             fire_any;

    // Lowest alive enemy in the LFSR-chosen column is the shooter.
    always_comb begin
        fire_col = COL_W'(32'(lfsr[3:0]) % N_COLS);
        fire_row = '0;
        fire_any = 1'b0;
        for (int unsigned r = 0; r < N_ROWS; r++)
            if (alive[r*N_COLS + 32'(fire_col)]) begin
                fire_row = ROW_W'(r);
                fire_any = 1'b1;
            end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr             <= 16'hACE1;
            shot_if.fire_req <= 1'b0;
            shot_if.fire_x   <= '0;
            shot_if.fire_y   <= '0;
        end else begin
            if (tick) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (shot_if.fire_ack) shot_if.fire_req <= 1'b0;
            if (tick && !restart && !shot_if.fire_req && fire_any &&
                (state == ST_MARCH || state == ST_DROP)) begin
                shot_if.fire_req <= 1'b1;
                shot_if.fire_x   <= 11'(12'(base_x) + 12'(fire_col) * 12'(DX) + 12'(SPR_W / 2));
                shot_if.fire_y   <= 11'(12'(base_y) + 12'(fire_row) * 12'(DY) + 12'(SPR_H - 1));
            end
        end
    end
`endif
endmodule
